edit_param_controller: RTL
==========================

# edit_param_controller

Sequencer for the clock/timer parameter-editing path. Tracks which of seven time parameters is selected and holds an editable BCD copy of each. Applies up/down adjustments with per-parameter wrap limits, then writes the edited set to the RTC write engine over a req/ack handshake. It sits between the debounced push-button pulses and the RTC bus controller, and drives the one-hot highlight consumed by the display.

## Interface
- N_PARAM, 7, number of editable parameters (fixed encoding below)
- BLINK_DIV, 25_000_000, clk cycles per half-period of the cursor blink (only with BLINK_EN)
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  edit mode request; level
- ld  in  1  one-cycle pulse: load snapshot into edit registers
- ld_data  in  56  snapshot, byte i = parameter i, BCD
- btn_up, btn_down, btn_left, btn_right, btn_save  in  1 each  one-cycle debounced pulses
- wr_req  out  1  write request to RTC engine
- wr_addr  out  3  parameter index being written
- wr_data  out  8  BCD value being written
- wr_ack  in  1  one-cycle acknowledge from RTC engine
- habilita  out  7  one-hot of selected parameter; all-zero outside EDIT
- value  out  8  BCD value of selected parameter
- busy  out  1  high in WRITE
- listo  out  1  one-cycle pulse when all 7 writes are acknowledged
- blink  out  1  cursor blink phase

## Operation
- Parameter encoding (index: name, min..max BCD): 0 sec 00..59, 1 min 00..59, 2 hour 00..23, 3 date 01..31, 4 month 01..12, 5 year 00..99, 6 weekday 01..07.
- FSM states: IDLE, EDIT, WRITE, DONE.
- IDLE: habilita=0, sel=0. en=1 -> EDIT. ld accepted in IDLE and EDIT; it overwrites all 7 registers. An ld value outside its range is clamped to min.
- EDIT:
  - btn_right: sel=(sel==6)?0:sel+1. btn_left: sel=(sel==0)?6:sel-1.
  - btn_up: reg[sel] BCD +1, max wraps to min. btn_down: BCD −1, min wraps to max.
  - BCD increment: units 9 -> 0 with tens +1. Decrement mirrors this.
- Priority within one cycle: btn_save > (up/down) > (left/right).
  - up with down: no value change.
  - left with right: no selection change.
  - Adjust and move in the same cycle: adjust applies to the old sel, then sel moves.
- btn_save in EDIT -> WRITE with idx=0. en=0 in EDIT -> IDLE, registers kept, no write.
- WRITE:
  - wr_req=1, wr_addr=idx, wr_data=reg[idx], held stable until wr_ack.
  - On wr_ack: idx==6 -> DONE, else idx+1.
  - Buttons, ld and en are ignored until WRITE exits, so a partial write never occurs.
- DONE: listo=1 for one cycle, then EDIT if en=1, else IDLE.
- wr_ack outside WRITE is ignored.

## Timing
- Reset values: state IDLE, sel 0, idx 0, all registers at their min value, wr_req 0, wr_addr 0, wr_data 0, habilita 0, value = reg[0] (00), busy 0, listo 0, blink 1.
- All outputs are registered. Button effect is visible one cycle after the pulse.
- btn_save at cycle t -> wr_req high from t+1.
- wr_ack at cycle t -> next address presented at t+1, with wr_req staying high (back-to-back allowed).
- listo asserts the cycle after the 7th wr_ack.
- Reset mid-WRITE: wr_req drops on the next edge. The RTC engine tolerates an abandoned request.

## Configuration
- BLINK_EN defined: a counter divides clk by BLINK_DIV. blink toggles each half-period while in EDIT and is forced to 1 outside EDIT. Any button pulse reloads the counter and sets blink=1, so the cursor stays visible after an edit.
- BLINK_EN undefined: no counter, blink tied to 1.

## Structure
- Shared package holds:
  - state encoding
  - parameter index constants (P_SEC..P_WDAY)
  - per-index BCD min/max constant arrays
- Sub-module bcd_step (combinational): in value, min, max, up/down -> out value with wrap. Instantiated once, muxed on sel.

## Test plan
- Reset, then en=1: habilita=7'b0000001, value=00, busy=0.
- Select sec, set reg=59, btn_up -> 00. Select month, set reg=01, btn_down -> 12. Select hour, set reg=09, btn_up -> 10.
- btn_left at sel=0 -> habilita=7'b1000000. btn_left with btn_right in the same cycle -> selection unchanged.
- ld with ld_data sec=45, min=30, hour=12, date=15, month=06, year=24, wday=03, then btn_save. Ack each request after 3 cycles -> writes (0,45)(1,30)(2,12)(3,15)(4,06)(5,24)(6,03) in order, listo one pulse, busy low after.
- During WRITE, drop en and press btn_up -> all 7 writes still complete with unchanged data, then IDLE.
- Reset asserted while idx=3 in WRITE -> wr_req 0 next cycle, state IDLE, all registers at min.

Source files
------------

// File: rtl/edit_param_controller_pkg.sv
// edit_param_controller_pkg: shared states, parameter indices and BCD limits
package edit_param_controller_pkg;
  localparam int N_PARAM = 7;
  localparam int BLINK_DIV = 25_000_000;
  typedef enum logic [1:0] {IDLE, EDIT, WRITE, DONE} state_t;
  localparam logic [2:0] P_SEC = 3'd0, P_MIN_IDX = 3'd1, P_HOUR = 3'd2, P_DATE = 3'd3;
  localparam logic [2:0] P_MONTH = 3'd4, P_YEAR = 3'd5, P_WDAY = 3'd6;
  localparam logic [7:0] P_MIN [N_PARAM] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01};
  localparam logic [7:0] P_MAX [N_PARAM] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h07};
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input int i);
    return (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v >= P_MIN[i] && v <= P_MAX[i]) ? v : P_MIN[i];
  endfunction
endpackage

// File: rtl/edit_param_controller_bcd_step.sv
// edit_param_controller_bcd_step: one BCD increment/decrement with wrap between mn and mx
module edit_param_controller_bcd_step (
  input  logic [7:0] v,
  input  logic [7:0] mn,
  input  logic [7:0] mx,
  input  logic       up,
  output logic [7:0] q
);
  always_comb
    q = up ? ((v == mx) ? mn : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1)
           : ((v == mn) ? mx : (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1);
endmodule

// File: rtl/edit_param_controller.sv
// edit_param_controller: edit/select/write sequencer for seven BCD time parameters
// Optional cursor blink divider enabled with `define BLINK_EN
module edit_param_controller
  import edit_param_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ld,
  input  logic [55:0] ld_data,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_save,
  output logic        wr_req,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic [6:0]  habilita,
  output logic [7:0]  value,
  output logic        busy,
  output logic        listo,
  output logic        blink
);
  state_t state, state_n;
  logic [2:0] sel, sel_n, idx, idx_n;
  logic [7:0] regs [N_PARAM];
  logic [7:0] regs_n [N_PARAM];
  logic [7:0] step;
  edit_param_controller_bcd_step u_step (
    .v(regs[sel]), .mn(P_MIN[sel]), .mx(P_MAX[sel]), .up(btn_up), .q(step)
  );
  always_comb begin
    state_n = state;
    sel_n = sel;
    idx_n = idx;
    regs_n = regs;
    case (state)
      IDLE: begin
        if (ld) for (int i = 0; i < N_PARAM; i++) regs_n[i] = clamp_bcd(ld_data[8*i +: 8], i);
        state_n = en ? EDIT : IDLE;
      end
      EDIT: begin
        if (btn_save) begin
          state_n = WRITE;
          idx_n = P_SEC;
        end else if (!en) state_n = IDLE;
        else begin
          if (ld) for (int i = 0; i < N_PARAM; i++) regs_n[i] = clamp_bcd(ld_data[8*i +: 8], i);
          else if (btn_up ^ btn_down) regs_n[sel] = step;
          if (btn_right && !btn_left) sel_n = (sel == P_WDAY) ? P_SEC : sel + 3'd1;
          else if (btn_left && !btn_right) sel_n = (sel == P_SEC) ? P_WDAY : sel - 3'd1;
        end
      end
      WRITE: if (wr_ack) begin
        state_n = (idx == P_WDAY) ? DONE : WRITE;
        idx_n = (idx == P_WDAY) ? P_SEC : idx + 3'd1;
      end
      default: state_n = en ? EDIT : IDLE;
    endcase
    if (state_n == IDLE) sel_n = P_SEC;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      sel <= P_SEC;
      idx <= P_SEC;
      regs <= P_MIN;
      wr_req <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      habilita <= '0;
      value <= P_MIN[0];
      busy <= 1'b0;
      listo <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      idx <= idx_n;
      regs <= regs_n;
      wr_req <= state_n == WRITE;
      wr_addr <= (state_n == WRITE) ? idx_n : '0;
      wr_data <= (state_n == WRITE) ? regs_n[idx_n] : '0;
      habilita <= (state_n == EDIT) ? 7'(1) << sel_n : '0;
      value <= regs_n[sel_n];
      busy <= state_n == WRITE;
      listo <= state_n == DONE;
    end
`ifdef BLINK_EN
  localparam int W = $clog2(BLINK_DIV);
  localparam logic [W-1:0] CNT_MAX = W'(BLINK_DIV - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst || state_n != EDIT || btn_up || btn_down || btn_left || btn_right || btn_save) begin
      cnt <= '0;
      blink <= 1'b1;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      blink <= ~blink;
    end else cnt <= cnt + 1'b1;
`else
  assign blink = 1'b1;
`endif
endmodule
